// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: R-type funct codes, ALUOp encodings and the
// mul/div sequencer state encoding.
package mips_pkg;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator for shift-add multiply / restoring divide, plus the final
// sign correction that turns magnitudes back into HI/LO values.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] load_lo_i,
  input  logic [XLEN-1:0] load_opnd_i,
  input  logic            neg_i,
  input  logic            rneg_i,
  input  logic            div0_i,
  input  logic [XLEN-1:0] dividend_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [2*XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN:0]   mul_next;
  logic [2*XLEN:0]   shl;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN:0]   div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  // The extra top bit keeps the carry of the upper-half add, so MULTU of
  // two all-ones operands cannot overflow.
  assign add_sum  = acc_q[2*XLEN:XLEN] + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {1'b0, add_sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN:1]};

  assign shl      = {acc_q[2*XLEN-1:0], 1'b0};
  assign diff     = {1'b0, shl[2*XLEN:XLEN]} - {2'b00, opnd_q};
  assign div_next = diff[XLEN+1] ? shl
                                 : {diff[XLEN:0], shl[XLEN-1:1], 1'b1};

  always_comb begin
    acc_d = acc_q;
    if (load_i)
      acc_d = {{(XLEN+1){1'b0}}, load_lo_i};
    else if (step_i)
      acc_d = is_div_i ? div_next : mul_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (load_i)
        opnd_q <= load_opnd_i;
    end
  end

  assign prod_fix = neg_i  ? -acc_q[2*XLEN-1:0]    : acc_q[2*XLEN-1:0];
  assign quot_fix = neg_i  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_i ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    hi_o = prod_fix[2*XLEN-1:XLEN];
    lo_o = prod_fix[XLEN-1:0];
    if (is_div_i) begin
      if (div0_i) begin
        hi_o = dividend_i;
        lo_o = '1;
      end else begin
        hi_o = rem_fix;
        lo_o = quot_fix;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage mul/div controller: owns HI/LO, the iteration counter and the
// busy/done handshake toward the hazard unit.
//
//   state | meaning
//   IDLE  | accepts MT writes and new mul/div ops
//   CALC  | XLEN shift-add / restoring-divide iterations
//   FIX   | sign correction, HI/LO commit at exit edge
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e         state_q;
  logic [CNT_W-1:0]  count_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q, rs_q;
  logic              is_div_q, neg_q, rneg_q, dz_q;

  logic              op_mul, op_div, op_signed, op_mthi, op_mtlo;
  logic              accept, load, step;
  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN-1:0]   dp_hi, dp_lo;

  assign op_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign op_mthi   = (funct == FUNCT_MTHI);
  assign op_mtlo   = (funct == FUNCT_MTLO);

  assign accept = (state_q == IDLE) && start && !flush;
  assign load   = accept && (op_mul || op_div);
  assign step   = (state_q == CALC) && !flush;

  assign rs_neg = op_signed && rs_val[XLEN-1];
  assign rt_neg = op_signed && rt_val[XLEN-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .step_i      (step),
    .is_div_i    (is_div_q),
    .load_lo_i   (op_div ? rs_mag : rt_mag),
    .load_opnd_i (op_div ? rt_mag : rs_mag),
    .neg_i       (neg_q),
    .rneg_i      (rneg_q),
    .div0_i      (dz_q),
    .dividend_i  (rs_q),
    .hi_o        (dp_hi),
    .lo_o        (dp_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      rs_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_mthi) hi_q <= rs_val;
            if (op_mtlo) lo_q <= rs_val;
            if (op_mul || op_div) begin
              is_div_q <= op_div;
              neg_q    <= rs_neg ^ rt_neg;
              rneg_q   <= rs_neg;
              dz_q     <= (rt_val == '0);
              rs_q     <= rs_val;
              count_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            count_q <= count_q + 1'b1;
            if (count_q == CNT_W'(XLEN-1))
              state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!flush) begin
            hi_q   <= dp_hi;
            lo_q   <= dp_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: vector table through a result scoreboard, plus
// hand-written MT, ignored-start, flush and async-reset sequences.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every done pulse pops one expected {hi,lo}.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hilo", {hi, lo}, e);
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy-high negedges until busy drops; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    check("busy_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    int d0;

    vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{FUNCT_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[5] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{FUNCT_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9] = '{FUNCT_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    #20 rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      d0 = done_cnt;
      exp_q.push_back({vecs[v].exp_hi, vecs[v].exp_lo});
      issue(vecs[v].f, vecs[v].rs, vecs[v].rt);
      wait_idle(n);
      check("busy_cycles", 64'(n), 64'd33);
      check("done_at_busy_fall", {63'd0, done}, 64'd1);
      @(negedge clk);
      check("done_single_pulse", {63'd0, done}, 64'd0);
      check("done_count", 64'(done_cnt - d0), 64'd1);
    end

    // MTHI / MTLO: single-cycle writes with no busy or done.
    d0 = done_cnt;
    issue(FUNCT_MTHI, 32'h00001234, 32'd0);
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    issue(FUNCT_MTLO, 32'h0F0F0F0F, 32'd0);
    @(negedge clk);
    check("mtlo_lo", 64'(lo), 64'h0F0F0F0F);
    check("mt_no_done", 64'(done_cnt - d0), 64'd0);

    // Ignored funct with start changes nothing.
    issue(FUNCT_ADD, 32'hDEADBEEF, 32'd1);
    @(negedge clk);
    check("ignored_funct_busy", {63'd0, busy}, 64'd0);
    check("ignored_funct_hilo", {hi, lo}, {32'h1234, 32'h0F0F0F0F});

    // Second start while busy must be ignored.
    d0 = done_cnt;
    exp_q.push_back({32'd0, 32'd30});
    issue(FUNCT_MULT, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    repeat (3) @(negedge clk);
    check("busy_start_ignored_done", 64'(done_cnt - d0), 64'd1);
    check("busy_start_ignored_busy", {63'd0, busy}, 64'd0);

    // Flush in IDLE suppresses start, including MT writes.
    @(posedge clk); #1 flush = 1'b1;
    start = 1'b1; funct = FUNCT_MTHI; rs_val = 32'hBADBAD00;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_mthi", 64'(hi), 64'd0);
    check("idle_flush_busy", {63'd0, busy}, 64'd0);

    // Known HI/LO, then MULT flushed at CALC cycle 10.
    issue(FUNCT_MTHI, 32'hAAAA5555, 32'd0);
    issue(FUNCT_MTLO, 32'h5A5A5A5A, 32'd0);
    d0 = done_cnt;
    issue(FUNCT_MULT, 32'd1234, 32'd5678);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hilo_hold", {hi, lo}, {32'hAAAA5555, 32'h5A5A5A5A});
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);

    // Async reset mid-CALC clears everything without a clock edge.
    issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'd3);
    repeat (8) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("areset_busy", {63'd0, busy}, 64'd0);
    check("areset_done", {63'd0, done}, 64'd0);
    check("areset_hilo", {hi, lo}, 64'd0);
    #13 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("areset_stays_idle", {63'd0, busy}, 64'd0);
    check("areset_hilo_after", {hi, lo}, 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
